// File: rtl/jk_flip_flop.sv
// WIDTH-bit JK flip-flop register with complementary outputs and synchronous
// active-high reset. Each bit holds, sets, clears or toggles from its own J/K pair.
module jk_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             CLK,
    output logic [WIDTH-1:0] Q,
    input  logic             RST,
    output logic [WIDTH-1:0] QN
);

    logic [WIDTH-1:0] q_next;

    // Explicit case per bit so that set/clear resolve an undefined Q, while
    // hold and toggle carry it forward.
    always_comb begin
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({J[i], K[i]})
                2'b10:   q_next[i] = 1'b1;
                2'b01:   q_next[i] = 1'b0;
                2'b11:   q_next[i] = ~Q[i];
                default: q_next[i] = Q[i];
            endcase
        end
    end

    // A floating (z) or x RST falls through to the J/K branch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= q_next;
        end
    end

    assign QN = ~Q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Bench for jk_flip_flop: a single-bit instance and a 4-bit instance with a
// non-zero reset value, checked against a per-bit behavioural model.
module tb_jk_flip_flop;

    logic       clk;
    logic       j1, k1, rst1;
    logic       q1, qn1;
    logic [3:0] j4, k4, q4, qn4;
    logic       rst4;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: known flag and value per bit.
    logic       m1_known, m1_val;
    logic [3:0] m4_known, m4_val;
    localparam logic [3:0] RV4 = 4'b1010;

    jk_flip_flop #(.WIDTH(1)) dut1 (
        .J(j1), .K(k1), .CLK(clk), .Q(q1), .RST(rst1), .QN(qn1)
    );

    jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
        .J(j4), .K(k4), .CLK(clk), .Q(q4), .RST(rst4), .QN(qn4)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Returns {known, value} for one bit after a rising edge.
    function automatic logic [1:0] model_bit(input logic known, input logic val,
                                             input logic j, input logic k,
                                             input logic rst, input logic rv);
        if (rst)          return {1'b1, rv};
        if (j && !k)      return 2'b11;
        if (!j && k)      return 2'b10;
        if (j && k)       return {known, ~val};
        return {known, val};
    endfunction

    // Wait for a rising edge, step past it, advance both models.
    task automatic tick();
        logic [1:0] r;
        @(posedge clk);
        #1;
        r = model_bit(m1_known, m1_val, j1, k1, rst1, 1'b0);
        m1_known = r[1];
        m1_val   = r[0];
        for (int i = 0; i < 4; i++) begin
            r = model_bit(m4_known[i], m4_val[i], j4[i], k4[i], rst4, RV4[i]);
            m4_known[i] = r[1];
            m4_val[i]   = r[0];
        end
    endtask

    task automatic drive1(input logic j, input logic k, input logic rst);
        @(negedge clk);
        j1 = j; k1 = k; rst1 = rst;
    endtask

    task automatic test_power_up_sequence();
        logic [1:0] seq [8];
        seq = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
        for (int s = 0; s < 8; s++) begin
            drive1(seq[s][1], seq[s][0], 1'b0);
            tick();
            if (m1_known) begin
                n_checks++;
                if (q1 !== m1_val || qn1 !== ~m1_val) begin
                    n_fail++;
                    $display("FAIL power_up step %0d: q=%b qn=%b expected q=%b", s, q1, qn1, m1_val);
                end
            end
        end
    endtask

    task automatic test_reset();
        drive1(1'b0, 1'b0, 1'b1);
        rst4 = 1'b1; j4 = 4'b0000; k4 = 4'b0000;
        tick();
        n_checks++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_w1: q=%b qn=%b expected q=0 qn=1", q1, qn1);
        end
        n_checks++;
        if (q4 !== 4'b1010 || qn4 !== 4'b0101) begin
            n_fail++;
            $display("FAIL reset_w4: q=%b qn=%b expected q=1010 qn=0101", q4, qn4);
        end
        @(negedge clk);
        rst4 = 1'b0;
        rst1 = 1'b0;
    endtask

    task automatic test_reset_priority();
        drive1(1'b0, 1'b1, 1'b0);
        tick();
        for (int e = 0; e < 3; e++) begin
            drive1(1'b1, 1'b1, 1'b1);
            tick();
            n_checks++;
            if (q1 !== 1'b0 || qn1 !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_priority edge %0d: q=%b qn=%b expected q=0 qn=1", e, q1, qn1);
            end
        end
        drive1(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: q=%b expected 1", q1);
        end
    endtask

    task automatic test_sync_reset();
        drive1(1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        j1 = 1'b0; k1 = 1'b0;
        #2 rst1 = 1'b1;
        #3 rst1 = 1'b0;
        tick();
        n_checks++;
        if (q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_reset_glitch: q=%b expected 1", q1);
        end
        @(negedge clk);
        rst1 = 1'b1;
        #8;
        n_checks++;
        if (q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_reset_early: q=%b expected 1 before edge", q1);
        end
        tick();
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_reset_edge: q=%b expected 0", q1);
        end
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    task automatic test_toggle();
        logic exp_q [$];
        drive1(1'b0, 1'b0, 1'b1);
        tick();
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        drive1(1'b1, 1'b1, 1'b0);
        for (int e = 0; e < 8; e++) begin
            tick();
            n_checks++;
            if (q1 !== exp_q[e] || qn1 !== ~exp_q[e]) begin
                n_fail++;
                $display("FAIL toggle edge %0d: q=%b qn=%b expected q=%b", e, q1, qn1, exp_q[e]);
            end
        end
        drive1(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_width4_mixed();
        @(negedge clk);
        rst4 = 1'b1; j4 = 4'b0000; k4 = 4'b0000;
        tick();
        n_checks++;
        if (q4 !== 4'b1010) begin
            n_fail++;
            $display("FAIL w4_reset: q=%b expected 1010", q4);
        end
        @(negedge clk);
        rst4 = 1'b0; j4 = 4'b0011; k4 = 4'b0101;
        tick();
        n_checks++;
        if (q4 !== 4'b1011 || qn4 !== 4'b0100) begin
            n_fail++;
            $display("FAIL w4_mixed: q=%b qn=%b expected q=1011 qn=0100", q4, qn4);
        end
        @(negedge clk);
        j4 = 4'b0000; k4 = 4'b0000;
    endtask

    task automatic test_mid_cycle();
        drive1(1'b1, 1'b0, 1'b0);
        tick();
        j1 = 1'b0; k1 = 1'b1;
        #4;
        j1 = 1'b0; k1 = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_cycle_falling: q=%b expected 1", q1);
        end
        tick();
        n_checks++;
        if (q1 !== 1'b1 || qn1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_cycle_rising: q=%b qn=%b expected q=1 qn=0", q1, qn1);
        end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            j1   = 1'($urandom_range(0, 1));
            k1   = 1'($urandom_range(0, 1));
            rst1 = ($urandom_range(0, 15) == 0);
            j4   = 4'($urandom_range(0, 15));
            k4   = 4'($urandom_range(0, 15));
            rst4 = ($urandom_range(0, 15) == 0);
            tick();
            if (m1_known) begin
                n_checks++;
                if (q1 !== m1_val || qn1 !== ~m1_val) begin
                    n_fail++;
                    $display("FAIL random_w1 cycle %0d: q=%b qn=%b expected q=%b", c, q1, qn1, m1_val);
                end
            end
            mask = m4_known;
            n_checks++;
            if ((q4 & mask) !== (m4_val & mask) || (qn4 & mask) !== (~m4_val & mask)) begin
                n_fail++;
                $display("FAIL random_w4 cycle %0d: q=%b qn=%b expected q=%b (known %b)",
                         c, q4, qn4, m4_val, mask);
            end
        end
    endtask

    initial begin
        j1 = 1'b0; k1 = 1'b0; rst1 = 1'b0;
        j4 = 4'b0000; k4 = 4'b0000; rst4 = 1'b0;
        m1_known = 1'b0; m1_val = 1'b0;
        m4_known = 4'b0000; m4_val = 4'b0000;

        test_power_up_sequence();
        test_reset();
        test_reset_priority();
        test_sync_reset();
        test_toggle();
        test_width4_mixed();
        test_mid_cycle();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_flip_flop.md
# jk_flip_flop

Edge-triggered JK flip-flop register, WIDTH bits wide, with complementary outputs and a synchronous active-high reset. Each bit independently holds, sets, clears or toggles on the rising clock edge according to its J/K pair. It is a generic sequential primitive for counters, toggle registers and teaching/demo datapaths. The default configuration (WIDTH=1) is a single classic JK flip-flop.

## Interface
- WIDTH, 1: number of independent JK bits; must be ≥1.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into Q when RST is asserted.
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  reset; synchronous and active-high. Sampled on the CLK rising edge only.
- J  input  WIDTH  per-bit set request.
- K  input  WIDTH  per-bit clear request.
- Q  output  WIDTH  registered state.
- QN  output  WIDTH  bitwise complement of Q, derived combinationally from the Q register.
- Positional port order is fixed: J, K, CLK, Q, RST, QN. Existing positional instances connect only J, K, CLK, Q. An unconnected RST (floating/z) must behave as deasserted. Write the reset as "if (RST)" so that z/x takes the non-reset branch.

## Operation
- Every rising CLK edge, per bit i, in priority order:
  - RST=1: Q[i] <= RESET_VALUE[i], regardless of J/K.
  - J=0, K=0: hold; Q[i] unchanged.
  - J=1, K=0: set; Q[i] <= 1.
  - J=0, K=1: clear; Q[i] <= 0.
  - J=1, K=1: toggle; Q[i] <= ~Q[i].
- Bits are fully independent. Mixed commands across bits in one cycle are legal.
- QN == ~Q at all times after Q is defined.
- No state machine beyond the WIDTH state bits. No enable and no asynchronous set/clear.
- Power-up: Q is undefined (x in simulation) until the first reset or the first set/clear edge on that bit.
  - Hold and toggle preserve the x.
  - Set and clear resolve it.
  - The RTL must not add an initial value.
- Reset mid-operation: a reset edge overrides any pending toggle. The next non-reset edge acts on RESET_VALUE.

## Timing
- Latency: 1 CLK edge from J/K/RST sampled to Q/QN updated. There is no combinational path from J, K or RST to Q or QN.
- J, K and RST must meet setup/hold around the CLK rising edge. Changes while CLK is low or high have no effect until the next rising edge.
- The falling edge of CLK has no effect.
- Toggle with J=K=1 held steady inverts Q on every rising edge; Q runs at half the CLK frequency.
- Reset takes effect at the first rising edge where RST=1. It is released at the first edge where RST=0, and that same edge applies J/K normally.

## Test plan
- WIDTH=1, RST floating, 10 ns per half-phase, J/K changed while CLK is low. Apply the sequence (0,0)→(1,0)→(0,1)→(1,1)→(0,0)→(1,0)→(0,1)→(1,1), one rising edge each. Required Q after each edge: x, 1, 0, 1, 1, 1, 0, 1. QN is the complement wherever Q is defined.
- Reset priority: Q=0, then RST=1 with J=K=1 for 3 edges → Q=RESET_VALUE (0) and QN=1 after each edge. Release RST with J=K=1 → Q=1 on the next edge.
- Synchronous reset check: pulse RST high and low entirely while CLK is low → Q unchanged. RST=1 sampled on a rising edge → Q=0 on that edge, not before.
- Sustained toggle: after reset, J=K=1 for 8 edges → Q sequence 1,0,1,0,1,0,1,0.
- WIDTH=4, RESET_VALUE=4'b1010: reset → Q=1010. Then J=4'b0011, K=4'b0101 (bit0 toggle, bit1 set, bit2 clear, bit3 hold) → Q=1011, QN=0100.
- Falling edge and mid-cycle changes: Q=1. Change J/K to (0,1) while CLK is high, then back to (0,0) before the next rising edge → Q remains 1.
